aes_inv_key_stream: RTL
=======================

Name: aes_inv_key_stream

Overview:
Byte-serial AES-128 round-key generator and streamer that feeds the decrypt control unit's 8-bit `key` input. It loads the 16-byte cipher key one byte per cycle and expands all 11 round keys (176 bytes) into an internal buffer. It then streams the round keys one byte per accepted cycle, in decryption order (round 10 down to round 0). The consumer paces the stream with a valid/ready handshake.

Parameters:
- REVERSE, 1, stream order: 1 = round 10→0 (decrypt), 0 = round 0→10 (encrypt).
- ROUNDS, 10, number of AES rounds; only 10 (AES-128) is supported, and any other value is an elaboration error.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- key_load  input  1  one-cycle pulse; key_in is captured as byte 0 on this cycle.
- key_in  input  8  cipher key byte; byte 0 is the MSB of w0.
- stream_start  input  1  starts a stream; honoured only in READY.
- key_ready_in  input  1  consumer accepts key_out this cycle.
- key_out  output  8  current round-key byte; 0 when key_valid=0.
- key_valid  output  1  key_out holds a valid stream byte.
- round_idx  output  4  round number of the current key_out byte (0..10).
- byte_idx  output  4  byte position 0..15 within the current round key.
- keys_ready  output  1  expansion complete and buffer valid.
- done  output  1  one-cycle pulse after the last stream byte is accepted.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; all counters 0.
  - key_out = 0, key_valid = 0, round_idx = 0, byte_idx = 0, keys_ready = 0, done = 0.
  - Buffer contents are don't-care.
- Storage: 176 x 8 register array. Address a = 4*i + j, where i is the word index 0..43 and j is the byte index 0..3 (j=0 is the MSB).
- FSM states: IDLE, LOAD, EXPAND, READY, STREAM.
- IDLE:
  - key_load=1 → write key_in to address 0, cnt = 1, go to LOAD.
- LOAD:
  - Each cycle, write key_in to address cnt and increment cnt.
  - The cycle that writes address 15 transitions to EXPAND with cnt = 16.
  - Key load is exactly 16 consecutive cycles; no stalling.
- EXPAND: one byte per cycle at address cnt (16..175), 160 cycles total.
  - If i mod 4 = 0: byte = w[i-4][j] ^ SBOX(w[i-1][(j+1) mod 4]) ^ (j==0 ? RCON[i/4] : 0).
  - Otherwise: byte = w[i-4][j] ^ w[i-1][j].
  - RCON[1..10] = 01,02,04,08,10,20,40,80,1b,36.
  - SBOX is the codebase's combinational forward S-box module, instantiated once.
  - After address 175 is written, go to READY; keys_ready goes to 1 on that same edge.
- READY:
  - keys_ready = 1.
  - stream_start=1 → go to STREAM with the stream counter at byte 0 of the first round (round 10 if REVERSE=1, round 0 if REVERSE=0).
- STREAM:
  - key_valid = 1.
  - key_out = buffer[16*round_idx + byte_idx], combinational from the registered indices.
  - key_valid & key_ready_in → advance byte_idx.
  - byte_idx wraps 15→0 and steps round_idx by −1 (REVERSE=1) or +1 (REVERSE=0).
  - Holding key_ready_in=0 holds key_out, round_idx and byte_idx stable indefinitely.
  - Acceptance of the 176th byte → done=1 for exactly the next cycle, key_valid=0, go to READY.
  - Keys are retained, so a new stream_start replays the stream without reloading.
- key_load in any state (LOAD, EXPAND, READY, STREAM):
  - Aborts the current activity.
  - keys_ready → 0, key_valid → 0, no done pulse.
  - The cycle's key_in is taken as byte 0 and the FSM restarts LOAD.
- Ignored inputs:
  - stream_start is ignored outside READY.
  - stream_start together with key_load: key_load wins.
  - key_ready_in is ignored when key_valid = 0.
- Reset asserted mid-LOAD, mid-EXPAND or mid-STREAM returns to IDLE immediately; keys_ready = 0 until a full reload and expansion completes.
- Latency:
  - 16 load cycles + 160 expansion cycles; keys_ready is high 176 cycles after the key_load cycle.
  - First key byte is valid 1 cycle after stream_start.
  - With key_ready_in tied high, a full stream takes 176 cycles.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, REVERSE=1, key_ready_in=1 → keys_ready rises 176 cycles after key_load. The first 16 bytes are d014f9a8c9ee2589e13f0cc8b6630ca6 (round_idx=10). Bytes 161..176 are the cipher key; the last byte is 3c. done pulses once.
- Same key, REVERSE=0 → bytes 17..32 are a0fafe1788542cb123a339392a6c7605 (round_idx=1). The final 16 bytes are d014f9a8c9ee2589e13f0cc8b6630ca6.
- Random key_ready_in backpressure (50%) → the stream equals the unstalled stream byte-for-byte; key_out, round_idx and byte_idx are stable while stalled. Compare against a software key-expansion model.
- Second stream_start in READY without reload → identical 176-byte stream.
- key_load asserted at EXPAND cycle 80 with key 000102030405060708090a0b0c0d0e0f → keys_ready stays 0, no done pulse. The later stream's round-10 key is 13111d7fe3944a17f307a78b4d2b30c5.
- reset pulse mid-STREAM → all outputs 0 asynchronously and state IDLE. stream_start afterwards is ignored (key_valid stays 0).

Source files
------------

// File: rtl/aes_inv_key_stream.sv
// Byte-serial AES-128 key expander with a 176-byte round-key buffer.
// Round keys stream out in decrypt (10..0) or encrypt (0..10) order.
module aes_sbox (
   input  logic [7:0] in_i,
   output logic [7:0] out_o
);
   localparam logic [7:0] SBOX [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };
   assign out_o = SBOX[in_i];
endmodule

module aes_inv_key_stream #(
   parameter int REVERSE = 1,
   parameter int ROUNDS  = 10
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       key_load,
   input  logic [7:0] key_in,
   input  logic       stream_start,
   input  logic       key_ready_in,
   output logic [7:0] key_out,
   output logic       key_valid,
   output logic [3:0] round_idx,
   output logic [3:0] byte_idx,
   output logic       keys_ready,
   output logic       done
);
   if (ROUNDS != 10) begin : g_rounds_check
      $error("aes_inv_key_stream supports only ROUNDS=10 (AES-128)");
   end

   localparam logic [3:0] FIRST_ROUND = (REVERSE != 0) ? 4'd10 : 4'd0;
   localparam logic [3:0] LAST_ROUND  = (REVERSE != 0) ? 4'd0  : 4'd10;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EXPAND, S_READY, S_STREAM} state_t;

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [3:0] round_q, round_d;
   logic [3:0] byte_q, byte_d;
   logic       done_q, done_d;
   logic [7:0] key_buf [176];

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   // cnt = 4*i + j; first word of each group of four takes RotWord/SubWord/Rcon.
   logic       rot_word;
   logic [1:0] j_sel;
   logic [7:0] prev_base, prev_addr, old_addr;
   logic [7:0] prev_byte, old_byte, sbox_out, exp_byte;

   assign rot_word  = (cnt_q[3:2] == 2'd0);
   assign j_sel     = rot_word ? cnt_q[1:0] + 2'd1 : cnt_q[1:0];
   assign prev_base = cnt_q - 8'd4;
   assign prev_addr = {prev_base[7:2], j_sel};
   assign old_addr  = cnt_q - 8'd16;
   assign prev_byte = key_buf[prev_addr];
   assign old_byte  = key_buf[old_addr];

   aes_sbox u_sbox (.in_i(prev_byte), .out_o(sbox_out));

   assign exp_byte = rot_word
      ? (old_byte ^ sbox_out ^ ((cnt_q[1:0] == 2'd0) ? rcon(cnt_q[7:4]) : 8'h00))
      : (old_byte ^ prev_byte);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         round_q <= 4'd0;
         byte_q  <= 4'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         round_q <= round_d;
         byte_q  <= byte_d;
         done_q  <= done_d;
      end
   end

   // Buffer contents are don't-care after reset, so the array carries no reset.
   always_ff @(posedge clock) begin
      if (key_load)
         key_buf[0] <= key_in;
      else if (state_q == S_LOAD)
         key_buf[cnt_q] <= key_in;
      else if (state_q == S_EXPAND)
         key_buf[cnt_q] <= exp_byte;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      round_d = round_q;
      byte_d  = byte_q;
      done_d  = 1'b0;
      if (key_load) begin
         state_d = S_LOAD;
         cnt_d   = 8'd1;
      end else begin
         case (state_q)
            S_LOAD: begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == 8'd15) state_d = S_EXPAND;
            end
            S_EXPAND: begin
               if (cnt_q == 8'd175) begin
                  state_d = S_READY;
                  cnt_d   = 8'd0;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            S_READY: begin
               if (stream_start) begin
                  state_d = S_STREAM;
                  round_d = FIRST_ROUND;
                  byte_d  = 4'd0;
               end
            end
            S_STREAM: begin
               if (key_ready_in) begin
                  if (byte_q != 4'd15) begin
                     byte_d = byte_q + 4'd1;
                  end else if (round_q == LAST_ROUND) begin
                     state_d = S_READY;
                     done_d  = 1'b1;
                  end else begin
                     byte_d  = 4'd0;
                     round_d = (REVERSE != 0) ? round_q - 4'd1 : round_q + 4'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      key_valid  = (state_q == S_STREAM);
      keys_ready = (state_q == S_READY) || (state_q == S_STREAM);
      key_out    = key_valid ? key_buf[{round_q, byte_q}] : 8'h00;
      round_idx  = round_q;
      byte_idx   = byte_q;
      done       = done_q;
   end
endmodule
